// File: rtl/fft_pkg.sv
// Shared types and limits for the radix-2 butterfly sequencer.
package fft_pkg;

   typedef enum logic [3:0] {
      LD_REA  = 4'd0,
      LD_IMA  = 4'd1,
      LD_REB  = 4'd2,
      LD_IMB  = 4'd3,
      LD_REW  = 4'd4,
      LD_IMW  = 4'd5,
      MUL     = 4'd6,
      CAL     = 4'd7,
      DSP_REY = 4'd8,
      DSP_IMY = 4'd9,
      DSP_REZ = 4'd10,
      DSP_IMZ = 4'd11
   } bfly_state_t;

   localparam int BFLY_N_OPERANDS     = 6;
   localparam int BFLY_MUL_CYCLES_MAX = 15;

endpackage

// File: rtl/fft_press_detect.sv
// Turns the push-button level into a one-cycle press pulse.
// FFT_READY_SYNC_EN adds a two-flop synchronizer ahead of the edge detector.
module fft_press_detect (
   input  logic Clock,
   input  logic nReset,
   input  logic ReadyIn,
   output logic press
);

   logic ready_s;
   logic prev_q, prev_d;
   logic press_q, press_d;

`ifdef FFT_READY_SYNC_EN
   logic sync1_q, sync2_q;

   // Synchronizer flops; reset high so a held button looks already pressed.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= ReadyIn;
         sync2_q <= sync1_q;
      end
   end

   assign ready_s = sync2_q;
`else
   assign ready_s = ReadyIn;
`endif

   // Rising-edge detection on the (optionally synchronized) level.
   always_comb begin
      prev_d  = ready_s;
      press_d = ready_s & ~prev_q;
   end

   // History resets to 1 so a button held through reset is not a press.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         prev_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/fft_bfly_sequencer.sv
// Butterfly control sequencer: six operand loads, multiply, add/sub, four result displays.
// Build option FFT_READY_SYNC_EN synchronizes ReadyIn inside fft_press_detect.
module fft_bfly_sequencer
   import fft_pkg::*;
#(
   parameter int MUL_CYCLES = 2
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       ReadyIn,
   output logic       load_Rea,
   output logic       load_Ima,
   output logic       load_Reb,
   output logic       load_Imb,
   output logic       load_Rew,
   output logic       load_Imw,
   output logic       mul_en,
   output logic       cal_en,
   output logic       display_Rey,
   output logic       display_Imy,
   output logic       display_Rez,
   output logic       display_Imz,
   output logic       busy,
   output logic [3:0] phase
);

   localparam int MUL_CLAMPED = (MUL_CYCLES > BFLY_MUL_CYCLES_MAX) ? BFLY_MUL_CYCLES_MAX :
                                ((MUL_CYCLES < 1) ? 1 : MUL_CYCLES);
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CLAMPED);

   logic                       press_s;
   logic [BFLY_N_OPERANDS-1:0] load_s;
   bfly_state_t                state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic                       mul_en_q, mul_en_d;
   logic                       cal_en_q, cal_en_d;
   logic                       busy_q, busy_d;
   logic [3:0]                 disp_q, disp_d;
   logic [3:0]                 phase_q, phase_d;

   fft_press_detect u_press (
      .Clock   (Clock),
      .nReset  (nReset),
      .ReadyIn (ReadyIn),
      .press   (press_s)
   );

   // Next-state and multiply counter; presses outside LD/DSP states are dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LD_REA, LD_IMA, LD_REB, LD_IMB, LD_REW, DSP_REY, DSP_IMY, DSP_REZ: begin
            if (press_s) state_d = bfly_state_t'(state_q + 4'd1);
            else         state_d = state_q;
         end
         LD_IMW: begin
            if (press_s) begin
               state_d = MUL;
               cnt_d   = MUL_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         MUL: begin
            if (cnt_q == 4'd1) state_d = CAL;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CAL:     state_d = DSP_REY;
         DSP_IMZ: begin
            if (press_s) state_d = LD_REA;
            else         state_d = state_q;
         end
         default: state_d = LD_REA;
      endcase
   end

   // Level outputs are decoded from the next state so they leave a flop.
   always_comb begin
      mul_en_d = (state_d == MUL);
      cal_en_d = (state_d == CAL);
      busy_d   = mul_en_d | cal_en_d;
      phase_d  = state_d;
      case (state_d)
         DSP_REY: disp_d = 4'b0001;
         DSP_IMY: disp_d = 4'b0010;
         DSP_REZ: disp_d = 4'b0100;
         DSP_IMZ: disp_d = 4'b1000;
         default: disp_d = 4'b0000;
      endcase
   end

   // Load strobes: one per press, only in the matching operand state.
   always_comb begin
      load_s = {BFLY_N_OPERANDS{1'b0}};
      case (state_q)
         LD_REA, LD_IMA, LD_REB, LD_IMB, LD_REW, LD_IMW: begin
            if (press_s) load_s = 6'b000001 << state_q;
            else         load_s = {BFLY_N_OPERANDS{1'b0}};
         end
         default: load_s = {BFLY_N_OPERANDS{1'b0}};
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= LD_REA;
         cnt_q    <= 4'd0;
         mul_en_q <= 1'b0;
         cal_en_q <= 1'b0;
         busy_q   <= 1'b0;
         disp_q   <= 4'b0000;
         phase_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_en_q <= mul_en_d;
         cal_en_q <= cal_en_d;
         busy_q   <= busy_d;
         disp_q   <= disp_d;
         phase_q  <= phase_d;
      end
   end

   assign load_Rea    = load_s[0];
   assign load_Ima    = load_s[1];
   assign load_Reb    = load_s[2];
   assign load_Imb    = load_s[3];
   assign load_Rew    = load_s[4];
   assign load_Imw    = load_s[5];
   assign mul_en      = mul_en_q;
   assign cal_en      = cal_en_q;
   assign busy        = busy_q;
   assign display_Rey = disp_q[0];
   assign display_Imy = disp_q[1];
   assign display_Rez = disp_q[2];
   assign display_Imz = disp_q[3];
   assign phase       = phase_q;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Self-checking bench for fft_bfly_sequencer: vector table, corner sequences and
// random button activity compared every cycle against a step-level reference model.
module tb_fft_bfly_sequencer;

   localparam int MC = 5;
`ifdef FFT_READY_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic Clock = 1'b0;
   logic nReset, ReadyIn;
   logic load_Rea, load_Ima, load_Reb, load_Imb, load_Rew, load_Imw;
   logic mul_en, cal_en, busy;
   logic display_Rey, display_Imy, display_Rez, display_Imz;
   logic [3:0] phase;

   always #5 Clock = ~Clock;

   fft_bfly_sequencer #(.MUL_CYCLES(MC)) dut (
      .Clock(Clock), .nReset(nReset), .ReadyIn(ReadyIn),
      .load_Rea(load_Rea), .load_Ima(load_Ima), .load_Reb(load_Reb),
      .load_Imb(load_Imb), .load_Rew(load_Rew), .load_Imw(load_Imw),
      .mul_en(mul_en), .cal_en(cal_en),
      .display_Rey(display_Rey), .display_Imy(display_Imy),
      .display_Rez(display_Rez), .display_Imz(display_Imz),
      .busy(busy), .phase(phase)
   );

   typedef struct {
      int         hold;
      logic [3:0] exp_phase;
      logic [5:0] exp_loads;
      logic [3:0] exp_disp;
      int         exp_mul;
   } vec_t;

   vec_t vecs [10];

   int checks = 0;
   int errors = 0;

   // Reference model: step index 0..11, remaining multiply cycles, button history.
   int   mstate, mleft;
   logic mpress;
   logic hist [0:3];

   int         strobe_cycles, mul_cnt, cal_cnt;
   logic [5:0] load_seen;

   function automatic logic [31:0] dut_vec();
      return {15'b0, load_Imw, load_Rew, load_Imb, load_Reb, load_Ima, load_Rea,
              mul_en, cal_en, busy, display_Imz, display_Rez, display_Imy, display_Rey, phase};
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [5:0] ld = 6'b0;
      logic [3:0] dp = 4'b0;
      if (mstate < 6 && mpress) ld = 6'b1 << mstate;
      if (mstate >= 8) dp = 4'b1 << (mstate - 8);
      return {15'b0, ld, (mstate == 6), (mstate == 7), (mstate == 6 || mstate == 7), dp, 4'(mstate)};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic clear_stats();
      strobe_cycles = 0;
      mul_cnt       = 0;
      cal_cnt       = 0;
      load_seen     = 6'b0;
   endtask

   // One clock: advance the model at the rising edge, compare at the falling edge.
   task automatic tick();
      @(posedge Clock);
      if (mstate < 6) begin
         if (mpress) begin
            mstate++;
            if (mstate == 6) mleft = MC;
         end
      end else if (mstate == 6) begin
         mleft--;
         if (mleft == 0) mstate = 7;
      end else if (mstate == 7) begin
         mstate = 8;
      end else if (mpress) begin
         mstate = (mstate == 11) ? 0 : mstate + 1;
      end
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ReadyIn;
      mpress = hist[LAT-1] & ~hist[LAT];
      @(negedge Clock);
      check("cycle", dut_vec(), exp_vec());
      strobe_cycles += ({load_Imw, load_Rew, load_Imb, load_Reb, load_Ima, load_Rea} != 6'b0) ? 1 : 0;
      load_seen |= {load_Imw, load_Rew, load_Imb, load_Reb, load_Ima, load_Rea};
      mul_cnt += mul_en ? 1 : 0;
      cal_cnt += cal_en ? 1 : 0;
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      #1;
      check("reset_outputs", dut_vec(), 32'b0);
      mstate = 0;
      mleft  = 0;
      mpress = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   task automatic press_once(input int hold, input int low);
      ReadyIn = 1'b1;
      repeat (hold) tick();
      ReadyIn = 1'b0;
      repeat (low) tick();
   endtask

   task automatic wait_mul(input string name);
      int guard = 0;
      while (!mul_en && guard < 12) begin
         tick();
         guard++;
      end
      check(name, (guard < 12) ? 1 : 0, 1);
   endtask

   initial begin
      vecs[0] = '{2, 4'd1,  6'b000001, 4'b0000, 0};
      vecs[1] = '{1, 4'd2,  6'b000010, 4'b0000, 0};
      vecs[2] = '{5, 4'd3,  6'b000100, 4'b0000, 0};
      vecs[3] = '{1, 4'd4,  6'b001000, 4'b0000, 0};
      vecs[4] = '{3, 4'd5,  6'b010000, 4'b0000, 0};
      vecs[5] = '{1, 4'd8,  6'b100000, 4'b0001, MC};
      vecs[6] = '{2, 4'd9,  6'b000000, 4'b0010, 0};
      vecs[7] = '{1, 4'd10, 6'b000000, 4'b0100, 0};
      vecs[8] = '{4, 4'd11, 6'b000000, 4'b1000, 0};
      vecs[9] = '{1, 4'd0,  6'b000000, 4'b0000, 0};

      nReset  = 1'b1;
      ReadyIn = 1'b1;
      mstate  = 0;
      mleft   = 0;
      mpress  = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b1;
      clear_stats();
      @(negedge Clock);

      // Button held through reset must not count; a fresh press loads Re(a).
      do_reset();
      repeat (6) tick();
      check("held_reset_strobes", strobe_cycles, 0);
      check("held_reset_phase", phase, 4'd0);
      ReadyIn = 1'b0;
      repeat (3) tick();
      clear_stats();
      press_once(2, 6);
      check("first_press_strobes", strobe_cycles, 1);
      check("first_press_load", load_seen, 6'b000001);
      check("first_press_phase", phase, 4'd1);

      // Full operation walk from the vector table.
      do_reset();
      repeat (2) tick();
      for (int v = 0; v < 10; v++) begin
         clear_stats();
         press_once(vecs[v].hold, 11);
         check("vec_phase", phase, vecs[v].exp_phase);
         check("vec_loads", load_seen, vecs[v].exp_loads);
         check("vec_strobes", strobe_cycles, (vecs[v].exp_loads != 6'b0) ? 1 : 0);
         check("vec_disp", {display_Imz, display_Rez, display_Imy, display_Rey}, vecs[v].exp_disp);
         check("vec_mul_cycles", mul_cnt, vecs[v].exp_mul);
         check("vec_cal_cycles", cal_cnt, (vecs[v].exp_mul != 0) ? 1 : 0);
      end

      // Button held 20 cycles across the last load, through MUL and CAL.
      repeat (5) press_once(1, 4);
      clear_stats();
      ReadyIn = 1'b1;
      repeat (20) tick();
      ReadyIn = 1'b0;
      repeat (4) tick();
      check("hold_strobes", strobe_cycles, 1);
      check("hold_load", load_seen, 6'b100000);
      check("hold_phase", phase, 4'd8);
      press_once(1, 5);
      check("hold_fresh_press", phase, 4'd9);
      repeat (3) press_once(1, 4);
      check("hold_wrap_phase", phase, 4'd0);

      // Presses toggled during MUL and CAL are dropped.
      repeat (5) press_once(1, 4);
      clear_stats();
      ReadyIn = 1'b1;
      tick();
      ReadyIn = 1'b0;
      wait_mul("busy_mul_start");
      ReadyIn = 1'b1; tick();
      ReadyIn = 1'b0; tick();
      ReadyIn = 1'b1; tick();
      ReadyIn = 1'b0;
      repeat (8) tick();
      check("busy_mul_cycles", mul_cnt, MC);
      check("busy_cal_cycles", cal_cnt, 1);
      check("busy_phase", phase, 4'd8);
      check("busy_disp", {display_Imz, display_Rez, display_Imy, display_Rey}, 4'b0001);
      repeat (4) press_once(1, 4);
      check("busy_wrap_phase", phase, 4'd0);
      check("busy_wrap_disp", {display_Imz, display_Rez, display_Imy, display_Rey}, 4'b0000);

      // Random button activity against the model.
      repeat (300) begin
         ReadyIn = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 4)) tick();
      end
      ReadyIn = 1'b0;
      repeat (20) tick();

      // Reset in the middle of MUL, then press latency check.
      do_reset();
      repeat (2) tick();
      repeat (5) press_once(1, 4);
      ReadyIn = 1'b1;
      tick();
      ReadyIn = 1'b0;
      wait_mul("midreset_mul_start");
      repeat (2) tick();
      check("midreset_in_mul", {mul_en, busy}, 2'b11);
      do_reset();
      check("midreset_phase", phase, 4'd0);
      repeat (3) tick();
      begin
         int lat = 0;
         clear_stats();
         ReadyIn = 1'b1;
         while (!load_Rea && lat < 10) begin
            tick();
            lat++;
         end
         check("press_latency", lat, LAT);
      end
      ReadyIn = 1'b0;
      repeat (5) tick();
      check("after_reset_load", load_seen, 6'b000001);
      check("after_reset_phase", phase, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
- Sequences one radix-2 butterfly operation on the FFT datapath: y = a + w·b, z = a − w·b.
- Collects six operands (Re/Im of a, b, w) from the shared switch bus, one per ReadyIn press.
- Runs the multiply phase for a fixed latency, then fires the add/sub phase.
- Steps the LED display through the four results on further presses. Sits between the push-button input and the datapath; replaces ad-hoc operand-load control.

Parameters:
- MUL_CYCLES, 2, number of cycles mul_en is held high (datapath multiplier latency); legal range 1..15.

Ports:
- Clock in 1: system clock, rising edge.
- nReset in 1: asynchronous, active-low reset.
- ReadyIn in 1: level from push button, active high; one press = one step.
- load_Rea, load_Ima, load_Reb, load_Imb, load_Rew, load_Imw out 1 each: single-cycle operand load strobes.
- mul_en out 1: multiplier enable.
- cal_en out 1: single-cycle add/sub strobe.
- display_Rey, display_Imy, display_Rez, display_Imz out 1 each: one-hot level LED mux select.
- busy out 1: high during MUL and CAL (presses ignored).
- phase out 4: current state encoding, for debug LEDs.

Behaviour:
- Reset (async, nReset=0):
  - State goes to LD_REA and the counter clears.
  - All strobes, enables, display selects and busy go to 0; phase=0.
  - The edge-detect history register goes to 1, so a button held through reset is not counted as a press.
- Press detection: press = ReadyIn_q & ~ReadyIn_prev, registered. This gives one cycle of latency from the ReadyIn rise to the press pulse. A press lasts exactly one cycle regardless of how long the button is held.
- State sequence (phase value in brackets):
  - LD_REA(0) → LD_IMA(1) → LD_REB(2) → LD_IMB(3) → LD_REW(4) → LD_IMW(5) → MUL(6) → CAL(7) → DSP_REY(8) → DSP_IMY(9) → DSP_REZ(10) → DSP_IMZ(11) → LD_REA.
  - Encodings 12..15 are unused; if reached, return to LD_REA next cycle with all outputs 0.
- LD_x states:
  - Wait for a press.
  - In the cycle the press is seen, the matching load_* is asserted (combinational from state & press) and the state advances on the next edge.
  - Exactly one load strobe per press; never two strobes in the same cycle.
- MUL:
  - mul_en=1 and busy=1 for exactly MUL_CYCLES consecutive cycles, counted by a 4-bit down-counter loaded on entry.
  - Exit to CAL when the counter reaches 1.
- CAL: cal_en=1 and busy=1 for exactly one cycle, then DSP_REY.
- DSP_x states:
  - The matching display_* is held high for the whole state, one-hot.
  - Each press advances to the next display state.
  - A press in DSP_IMZ returns to LD_REA; display goes all-zero from the next cycle.
- Presses during MUL/CAL are dropped, not queued. A button still held when DSP_REY is entered does not generate a press; only a fresh 0→1 transition counts.
- Mid-operation reset: outputs go to 0 asynchronously. Operands already loaded in the datapath are not this block's concern; the sequence restarts at LD_REA.
- No combinational path from ReadyIn to any output.

Optional Feature:
- Macro: FFT_READY_SYNC_EN.
- Defined: ReadyIn passes through a two-flop synchronizer (both flops reset to 1) before edge detection. Press-to-strobe latency is 3 cycles.
- Undefined: ReadyIn_q = ReadyIn directly. Latency is 1 cycle; the input is assumed already synchronous.
- Sequencing is otherwise identical.

Decomposition:
- Shared package fft_pkg holds:
  - typedef enum logic [3:0] bfly_state_t with the encodings above.
  - Constant BFLY_N_OPERANDS=6.
  - Constant BFLY_MUL_CYCLES_MAX=15.
- Sub-module: fft_press_detect (optional synchronizer + rising-edge pulse, ports Clock, nReset, ReadyIn, press). The FSM and counter stay in fft_bfly_sequencer.

Test Plan:
1. Reset with ReadyIn held high, then release and press once → no strobe during the hold; on the press, load_Rea high for exactly 1 cycle; phase goes 0→1.
2. Six presses, each spaced ≥3 cycles, MUL_CYCLES=2 → load_Rea..load_Imw fire in order, one each. mul_en is high for 2 cycles, then cal_en for 1 cycle, then display_Rey=1 and phase=8.
3. Button held for 20 cycles across the LD_IMW press, through MUL and CAL → only load_Imw is counted; the state stays DSP_REY until the button is released and pressed again.
4. Press pulses injected during MUL and CAL with MUL_CYCLES=5 → ignored. mul_en is exactly 5 cycles and the state reaches DSP_REY unchanged.
5. Four presses in the DSP states → display_Rey→Imy→Rez→Imz, one-hot each cycle. The 4th press returns to phase=0 with all display_* = 0.
6. nReset asserted for 1 cycle while in MUL at count 3 → mul_en and busy drop immediately and phase=0. The next press yields load_Rea. Repeat the scenario with FFT_READY_SYNC_EN defined and check 3-cycle latency.
